neq_check_monitor: RTL

NEQ_CHECK_MONITOR -- requirements
Module: neq_check_monitor

---
 rtl/neq_check_monitor.sv | 113 +++++++++++
 1 files changed

// File: rtl/neq_check_monitor.sv
// Run-based checker for an upstream != stage: counts accepted vectors and
// mismatches against the golden compare, and records the first failing index.
module neq_check_monitor #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_VEC = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             neq_in,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             passed,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_vld
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic             fvld_q, fvld_d;

  logic accept;
  logic golden;
  logic mismatch;

  always_comb begin
    accept   = in_valid && (state_q == S_RUN);
    golden   = (a != b);
    // X/Z on the observed result must register as a failure, hence !==.
    mismatch = (neq_in !== golden);
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fvld_d  = fvld_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          vec_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          fvld_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (accept) begin
          vec_d = vec_q + CNT_W'(1);
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + CNT_W'(1);
            end
            if (!fvld_q) begin
              fidx_d = vec_q;
              fvld_d = 1'b1;
            end
          end
          if (vec_q == LAST_IDX) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fvld_q  <= fvld_d;
    end
  end

  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign in_ready      = busy;
  assign passed        = done && (err_q == '0);
  assign vec_count     = vec_q;
  assign err_count     = err_q;
  assign first_err_idx = fidx_q;
  assign first_err_vld = fvld_q;

endmodule
